// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
//
// Byte-stream boot loader that sits in front of the cpu. It receives a framed
// program image, for example from a UART receiver. It packs the bytes into
// 32-bit little-endian words and writes them into the cpu instruction/data
// RAM. It keeps the cpu in reset until the whole image has arrived and its
// checksum matches. On hardware this takes the place of initialising the RAM
// from the ram.hex file in simulation.
//
// Frame layout, one byte per accepted transfer:
//   MAGIC, LEN_LO, LEN_HI, 4*N data bytes (LSB first per word), CSUM
//   - N is the 16-bit word count.
//   - CSUM is the 8-bit wrap-around sum of all 4*N data bytes.
//
// Parameters:
//   ADDR_WIDTH  RAM word-address width; capacity is 2**ADDR_WIDTH words
//   MAGIC       frame start byte
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous, active-high reset
//   rx_valid   a byte is available on rx_data
//   rx_data    incoming byte
//   rx_ready   loader takes the byte this cycle (transfer on valid & ready)
//   mem_we     one-cycle RAM write strobe
//   mem_addr   RAM word address
//   mem_wdata  RAM write data
//   cpu_hold   keeps the cpu in reset while high
//   done       image loaded and checksum good (sticky until rst)
//   error      frame rejected (sticky until rst)
// ---------------------------------------------------------------------------
module ram_loader #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter logic [7:0]  MAGIC      = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    // Number of words the RAM can hold. A frame whose header asks for more
    // than this is rejected, so mem_addr can never wrap.
    localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic [15:0] count;
    logic [15:0] word_idx;
    logic [1:0]  byte_idx;
    logic [23:0] word_buf;
    logic [7:0]  sum;

    logic        accept;
    logic [15:0] len_full;

    // A byte moves only on the valid/ready handshake.
    assign accept = rx_valid & rx_ready;

    // Full word count. It is formed while the high length byte is on rx_data;
    // the low byte was latched on the previous accepted transfer.
    assign len_full = {rx_data, count[7:0]};

    // Frame parser and all registered outputs.
    //
    // rx_ready comes out of reset low. It goes high on the first clock edge
    // after reset and stays high until a terminal state is reached.
    //
    // The RAM write is registered. mem_we and its address and data therefore
    // appear in the cycle after the fourth byte of a word is accepted. This
    // lets the next word's first byte be accepted in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SYNC;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            count     <= 16'd0;
            word_idx  <= 16'd0;
            byte_idx  <= 2'd0;
            word_buf  <= 24'd0;
            sum       <= 8'd0;
        end else begin
            mem_we   <= 1'b0;
            rx_ready <= (state != DONE) && (state != ERR);

            if (accept) begin
                case (state)
                    SYNC: begin
                        // Bytes that are not MAGIC are line noise and are dropped.
                        if (rx_data == MAGIC) begin
                            state    <= LEN0;
                            word_idx <= 16'd0;
                            byte_idx <= 2'd0;
                            sum      <= 8'd0;
                        end
                    end

                    LEN0: begin
                        count[7:0] <= rx_data;
                        state      <= LEN1;
                    end

                    LEN1: begin
                        count <= len_full;
                        if (len_full == 16'd0) begin
                            state <= CSUM;
                        end else if ({16'd0, len_full} > CAPACITY) begin
                            state    <= ERR;
                            error    <= 1'b1;
                            rx_ready <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end

                    DATA: begin
                        sum <= sum + rx_data;
                        case (byte_idx)
                            2'd0: word_buf[7:0]   <= rx_data;
                            2'd1: word_buf[15:8]  <= rx_data;
                            2'd2: word_buf[23:16] <= rx_data;
                            default: begin
                                // The fourth byte completes the word. Write it
                                // straight from rx_data so no extra cycle is
                                // spent buffering it.
                                mem_we    <= 1'b1;
                                mem_wdata <= {rx_data, word_buf};
                                mem_addr  <= word_idx[ADDR_WIDTH-1:0];
                                word_idx  <= word_idx + 16'd1;
                                if (word_idx == count - 16'd1) begin
                                    state <= CSUM;
                                end
                            end
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                    end

                    CSUM: begin
                        rx_ready <= 1'b0;
                        if (rx_data == sum) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// ---------------------------------------------------------------------------
// tb_ram_loader
//
// Directed testbench for ram_loader. The loader is built with ADDR_WIDTH=4,
// so the capacity boundary (16 words) can be exercised with short frames.
//
// Expected outputs come from a stream model. Every accepted byte is kept.
// On each cycle the model parses the whole accepted history from scratch,
// finding the magic byte, the length, the data words and the checksum. It
// derives the expected handshake, write strobe, address, data and status
// from that parse.
//
// Literal checks after each frame pin the model to hand-computed results.
// ---------------------------------------------------------------------------
module tb_ram_loader;

    localparam int          AW    = 4;
    localparam int          CAP   = 16;
    localparam logic [7:0]  MAGIC = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    ram_loader #(
        .ADDR_WIDTH(AW),
        .MAGIC     (MAGIC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Accepted byte history and model handshake state
    logic [7:0] rxq[$];
    bit         m_ready = 1'b0;
    bit         m_acc   = 1'b0;

    // Image captured from the write port, for literal checks
    logic [31:0] ram[CAP];
    int          wr_count = 0;

    logic [7:0] frame[$];

    typedef struct {
        int          status;     // 0 running, 1 done, 2 error
        int          words;      // complete words received
        logic [31:0] last_data;
        int          last_addr;
        bit          word_edge;  // newest byte completed a data word
    } parse_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Parse the accepted byte history and report what the loader must show.
    function automatic parse_t parseStream();
        parse_t     r;
        int         i;
        int         n;
        int         ds;
        int         avail;
        int         b;
        logic [7:0] s;
        r = '{status: 0, words: 0, last_data: 32'd0, last_addr: 0, word_edge: 1'b0};
        i = 0;
        while (i < rxq.size() && rxq[i] != MAGIC) i++;
        if (rxq.size() < i + 3) return r;
        n = int'(rxq[i+1]) + 256 * int'(rxq[i+2]);
        if (n > CAP) begin
            r.status = 2;
            return r;
        end
        ds    = i + 3;
        avail = rxq.size() - ds;
        if (avail > 4 * n) avail = 4 * n;
        s = 8'd0;
        for (int j = 0; j < avail; j++) s = s + rxq[ds+j];
        r.words = avail / 4;
        if (r.words > 0) begin
            b           = ds + 4 * (r.words - 1);
            r.last_addr = r.words - 1;
            r.last_data = {rxq[b+3], rxq[b+2], rxq[b+1], rxq[b]};
        end
        r.word_edge = (avail > 0) && (avail % 4 == 0) && (rxq.size() == ds + avail);
        if (rxq.size() > ds + 4 * n) r.status = (rxq[ds+4*n] == s) ? 1 : 2;
        return r;
    endfunction

    // Model: records which bytes were transferred, using its own idea of ready.
    always @(posedge clk or posedge rst) begin
        parse_t pr;
        bit     acc;
        if (rst) begin
            rxq.delete();
            m_ready <= 1'b0;
            m_acc   <= 1'b0;
        end else begin
            acc = rx_valid && m_ready;
            if (acc) rxq.push_back(rx_data);
            pr = parseStream();
            m_acc   <= acc;
            m_ready <= (pr.status == 0);
        end
    end

    // Compare process: checks every output on every falling edge.
    always @(negedge clk) begin
        parse_t pr;
        if (rst) begin
            checkOutput("rst rx_ready",  32'(rx_ready),  32'd0);
            checkOutput("rst mem_we",    32'(mem_we),    32'd0);
            checkOutput("rst mem_addr",  32'(mem_addr),  32'd0);
            checkOutput("rst mem_wdata", mem_wdata,      32'd0);
            checkOutput("rst cpu_hold",  32'(cpu_hold),  32'd1);
            checkOutput("rst done",      32'(done),      32'd0);
            checkOutput("rst error",     32'(error),     32'd0);
        end else begin
            pr = parseStream();
            checkOutput("rx_ready",   32'(rx_ready), 32'(m_ready));
            checkOutput("mem_we",     32'(mem_we),   32'(m_acc && pr.word_edge));
            checkOutput("mem_addr",   32'(mem_addr), 32'(pr.last_addr));
            checkOutput("mem_wdata",  mem_wdata,     pr.last_data);
            checkOutput("done",       32'(done),     32'(pr.status == 1));
            checkOutput("error",      32'(error),    32'(pr.status == 2));
            checkOutput("cpu_hold",   32'(cpu_hold), 32'(pr.status != 1));
            checkOutput("done&error", 32'(done & error), 32'd0);
            if (mem_we) begin
                ram[mem_addr] = mem_wdata;
                wr_count++;
            end
        end
    end

    // Offer one byte until it is taken. With jitter, rx_valid is randomised
    // every cycle. The transfer completes on the posedge after the negedge
    // where valid and ready are both high.
    task automatic applyStimulus(input logic [7:0] b, input bit jitter);
        int waited = 0;
        bit sent   = 1'b0;
        while (!sent && waited < 200) begin
            @(negedge clk);
            rx_data  = b;
            rx_valid = jitter ? ($urandom_range(0, 1) == 1) : 1'b1;
            sent     = rx_valid && rx_ready;
            waited++;
        end
        if (!sent) begin
            tests++;
            fails++;
            $display("[TB] FAIL byte timeout: byte 0x%0h not accepted, rx_ready=%0b, expected 1", b, rx_ready);
        end
    endtask

    task automatic sendFrame(input bit jitter);
        foreach (frame[i]) applyStimulus(frame[i], jitter);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset mid-cycle and check that the outputs clear at once.
    task automatic doReset();
        @(negedge clk);
        rx_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        checkOutput("async rst mem_wdata", mem_wdata,        32'd0);
        checkOutput("async rst mem_we",    32'(mem_we),      32'd0);
        checkOutput("async rst cpu_hold",  32'(cpu_hold),    32'd1);
        checkOutput("async rst done",      32'(done),        32'd0);
        checkOutput("async rst error",     32'(error),       32'd0);
        checkOutput("async rst rx_ready",  32'(rx_ready),    32'd0);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        wr_count = 0;
        foreach (ram[i]) ram[i] = 32'd0;
    endtask

    task automatic loadExample1();
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    endtask

    task automatic checkExample1(input string tag);
        checkOutput({tag, " writes"}, 32'(wr_count), 32'd2);
        checkOutput({tag, " ram0"},   ram[0],        32'h0000_0013);
        checkOutput({tag, " ram1"},   ram[1],        32'h0010_0093);
        checkOutput({tag, " done"},   32'(done),     32'd1);
        checkOutput({tag, " hold"},   32'(cpu_hold), 32'd0);
        checkOutput({tag, " error"},  32'(error),    32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        #1 rst = 1'b1;
        doReset();

        // Two-word program image
        loadExample1();
        sendFrame(1'b0);
        checkOutput("t1 done next cycle", 32'(done), 32'd1);
        idle(3);
        checkExample1("t1");
        checkOutput("t1 rx_ready", 32'(rx_ready), 32'd0);

        // Leading garbage is skipped
        doReset();
        frame = {8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h38};
        sendFrame(1'b0);
        idle(3);
        checkOutput("t2 writes", 32'(wr_count), 32'd1);
        checkOutput("t2 ram0",   ram[0],        32'hDEAD_BEEF);
        checkOutput("t2 done",   32'(done),     32'd1);

        // Bad checksum
        doReset();
        frame = {8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        sendFrame(1'b0);
        idle(3);
        checkOutput("t3 writes",   32'(wr_count), 32'd1);
        checkOutput("t3 error",    32'(error),    32'd1);
        checkOutput("t3 done",     32'(done),     32'd0);
        checkOutput("t3 hold",     32'(cpu_hold), 32'd1);
        checkOutput("t3 rx_ready", 32'(rx_ready), 32'd0);

        // One word more than capacity
        doReset();
        frame = {8'hA5, 8'h11, 8'h00};
        sendFrame(1'b0);
        idle(5);
        checkOutput("t4a error",  32'(error),    32'd1);
        checkOutput("t4a writes", 32'(wr_count), 32'd0);
        checkOutput("t4a hold",   32'(cpu_hold), 32'd1);

        // Exactly capacity: byte j of word k is 4k+j, sum 0..63 = 0x7E0
        doReset();
        frame = {8'hA5, 8'h10, 8'h00};
        for (int k = 0; k < 64; k++) frame.push_back(8'(k));
        frame.push_back(8'hE0);
        sendFrame(1'b0);
        idle(3);
        checkOutput("t4b writes", 32'(wr_count), 32'd16);
        checkOutput("t4b ram0",   ram[0],        32'h0302_0100);
        checkOutput("t4b ram15",  ram[15],       32'h3F3E_3D3C);
        checkOutput("t4b done",   32'(done),     32'd1);

        // Reset in the middle of the second word, then resend
        doReset();
        frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
        sendFrame(1'b0);
        checkOutput("t5 writes before rst", 32'(wr_count), 32'd1);
        doReset();
        loadExample1();
        sendFrame(1'b0);
        idle(3);
        checkExample1("t5");

        // Empty image
        doReset();
        frame = {8'hA5, 8'h00, 8'h00, 8'h00};
        sendFrame(1'b0);
        idle(3);
        checkOutput("t6a writes", 32'(wr_count), 32'd0);
        checkOutput("t6a done",   32'(done),     32'd1);

        // Two-word image again with rx_valid toggling at random
        doReset();
        loadExample1();
        sendFrame(1'b1);
        idle(3);
        checkExample1("t6b");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
